apb_master_slave_pair: RTL and testbench

- Self-contained APB-style link: a requester-driven master FSM plus a zero/fixed-wait-state register-file slave, wired together internally.
- Master turns a simple request (PSEL, transfer, PWRITE, PADDR, PDATA) into APB SETUP/ACCESS phases.
- Slave commits writes to, and returns reads from, a small word-addressed memory.
- Used as the bus-protocol reference block for exercising APB timing.

---
 rtl/apb_master_slave_pair_if.sv | 31 +++
 rtl/apb_master_slave_pair.sv | 116 +++++++++++
 tb/tb_apb_master_slave_pair.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_slave_pair_if.sv
// Bus bundle for apb_master_slave_pair: requester inputs plus the APB-side
// outputs the block drives back to the requester.
`timescale 1ns/1ps

interface apb_master_slave_pair_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              transfer;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PDATA;
    logic              PENABLE;
    logic [ADDR_W-1:0] PRWADDR;
    logic [DATA_W-1:0] PRWDATA;
    logic [DATA_W-1:0] PRDATA1;
    logic              PREADY;

    // Requester side: issues requests and observes bus activity.
    modport master (
        output PSEL, transfer, PWRITE, PADDR, PDATA,
        input  PENABLE, PRWADDR, PRWDATA, PRDATA1, PREADY
    );

    // Block side: the master FSM and register-file slave behind it.
    modport slave (
        input  PSEL, transfer, PWRITE, PADDR, PDATA,
        output PENABLE, PRWADDR, PRWDATA, PRDATA1, PREADY
    );
endinterface

// File: rtl/apb_master_slave_pair.sv
// APB master FSM wired to a register-file slave with a fixed number of wait
// states; the master turns simple requests into SETUP/ACCESS phases.
`timescale 1ns/1ps

module apb_master_slave_pair #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb_master_slave_pair_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] rw_addr;
    logic [DATA_W-1:0] rw_data;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic             request;
    logic             enable;
    logic             ready;
    logic [IDX_W-1:0] word_idx;
    logic             addr_unused;

    assign request  = bus.PSEL & bus.transfer;
    // Decoded straight from the state register so PENABLE cannot glitch.
    assign enable   = (state == ACCESS);
    assign ready    = bus.PSEL & enable & (wait_cnt == CNT_W'(WAIT_STATES));
    assign word_idx = rw_addr[IDX_W+1:2];

    // Byte lane and high address bits are deliberately ignored (wrap modulo DEPTH*4).
    assign addr_unused = ^{rw_addr[ADDR_W-1:IDX_W+2], rw_addr[1:0]};

    assign bus.PENABLE = enable;
    assign bus.PREADY  = ready;
    assign bus.PRWADDR = rw_addr;
    assign bus.PRWDATA = rw_data;
    assign bus.PRDATA1 = rd_data;

    // Master FSM: address/data registers load only when a new SETUP begins.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            rw_addr <= '0;
            rw_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        state   <= SETUP;
                        rw_addr <= bus.PADDR;
                        rw_data <= bus.PDATA;
                    end
                end
                SETUP: begin
                    state <= bus.PSEL ? ACCESS : IDLE;
                end
                ACCESS: begin
                    if (!bus.PSEL) begin
                        state <= IDLE;
                    end else if (ready) begin
                        if (request) begin
                            state   <= SETUP;
                            rw_addr <= bus.PADDR;
                            rw_data <= bus.PDATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Wait counter: counts stalled ACCESS cycles, clears on completion or idle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (bus.PSEL && enable && !ready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Slave register file.
    // NOTE: the memory is cleared on reset because unwritten words must read
    // back as zero; that forces flops rather than a RAM macro for this array.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else if (ready) begin
            if (bus.PWRITE) begin
                mem[word_idx] <= rw_data;
            end else begin
                rd_data <= mem[word_idx];
            end
        end
    end
endmodule

// File: tb/tb_apb_master_slave_pair.sv
// Directed bench for apb_master_slave_pair: one zero-wait instance and one
// two-wait-state instance, each scenario checked against hand-derived values.
`timescale 1ns/1ps

module tb_apb_master_slave_pair;
    logic PCLK = 1'b0;
    logic PRESET;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 PCLK = ~PCLK;

    apb_master_slave_pair_if b0 ();
    apb_master_slave_pair_if b2 ();

    apb_master_slave_pair #(.WAIT_STATES(0)) u_dut0 (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (b0.slave)
    );

    apb_master_slave_pair #(.WAIT_STATES(2)) u_dut2 (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (b2.slave)
    );

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle0();
        b0.PSEL = 1'b0; b0.transfer = 1'b0; b0.PWRITE = 1'b0;
        b0.PADDR = '0;  b0.PDATA = '0;
    endtask

    task automatic idle2();
        b2.PSEL = 1'b0; b2.transfer = 1'b0; b2.PWRITE = 1'b0;
        b2.PADDR = '0;  b2.PDATA = '0;
    endtask

    // One complete zero-wait transfer on instance 0; ends in IDLE.
    task automatic xfer0(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        b0.PSEL = 1'b1; b0.transfer = 1'b1; b0.PWRITE = wr;
        b0.PADDR = addr; b0.PDATA = data;
        step();
        b0.transfer = 1'b0;
        step();
        step();
        idle0();
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        idle0();
        idle2();
        step();
        // A request held during reset must be ignored.
        b0.PSEL = 1'b1; b0.transfer = 1'b1; b0.PWRITE = 1'b1;
        b0.PADDR = 32'h40; b0.PDATA = 32'h1234;
        step();
        tests_run++;
        if (b0.PENABLE !== 1'b0) begin tests_failed++; $display("FAIL reset_penable: got %b want 0", b0.PENABLE); end
        tests_run++;
        if (b0.PREADY !== 1'b0) begin tests_failed++; $display("FAIL reset_pready: got %b want 0", b0.PREADY); end
        tests_run++;
        if (b0.PRWADDR !== 32'h0) begin tests_failed++; $display("FAIL reset_prwaddr: got %h want 0", b0.PRWADDR); end
        tests_run++;
        if (b0.PRWDATA !== 32'h0) begin tests_failed++; $display("FAIL reset_prwdata: got %h want 0", b0.PRWDATA); end
        tests_run++;
        if (b0.PRDATA1 !== 32'h0) begin tests_failed++; $display("FAIL reset_prdata1: got %h want 0", b0.PRDATA1); end
        tests_run++;
        if (b2.PENABLE !== 1'b0 || b2.PRDATA1 !== 32'h0) begin
            tests_failed++; $display("FAIL reset_dut2: got penable %b prdata1 %h want 0 0", b2.PENABLE, b2.PRDATA1);
        end
        PRESET = 1'b0;
        idle0();
        step();
    endtask

    // Back-to-back writes: 15 -> addr 4, then 0x22 -> addr 16.
    task automatic test_write();
        b0.PSEL = 1'b1; b0.transfer = 1'b1; b0.PWRITE = 1'b1;
        b0.PADDR = 32'd4; b0.PDATA = 32'd15;
        step();
        tests_run++;
        if (b0.PENABLE !== 1'b0 || b0.PREADY !== 1'b0) begin
            tests_failed++; $display("FAIL write_setup_phase: got penable %b pready %b want 0 0", b0.PENABLE, b0.PREADY);
        end
        tests_run++;
        if (b0.PRWADDR !== 32'd4 || b0.PRWDATA !== 32'd15) begin
            tests_failed++; $display("FAIL write_load: got addr %h data %h want 4 f", b0.PRWADDR, b0.PRWDATA);
        end
        b0.PADDR = 32'd16; b0.PDATA = 32'h22;
        step();
        tests_run++;
        if (b0.PENABLE !== 1'b1 || b0.PREADY !== 1'b1) begin
            tests_failed++; $display("FAIL write_access_phase: got penable %b pready %b want 1 1", b0.PENABLE, b0.PREADY);
        end
        tests_run++;
        if (b0.PRWADDR !== 32'd4) begin tests_failed++; $display("FAIL write_addr_hold: got %h want 4", b0.PRWADDR); end
        step();
        tests_run++;
        if (b0.PENABLE !== 1'b0 || b0.PRWADDR !== 32'd16 || b0.PRWDATA !== 32'h22) begin
            tests_failed++;
            $display("FAIL b2b_reload: got penable %b addr %h data %h want 0 10 22", b0.PENABLE, b0.PRWADDR, b0.PRWDATA);
        end
        step();
        b0.transfer = 1'b0;
        #1;
        tests_run++;
        if (b0.PENABLE !== 1'b1 || b0.PREADY !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_access: got penable %b pready %b want 1 1", b0.PENABLE, b0.PREADY);
        end
        step();
        tests_run++;
        if (b0.PENABLE !== 1'b0) begin tests_failed++; $display("FAIL write_to_idle: got %b want 0", b0.PENABLE); end
        idle0();
        step();
    endtask

    task automatic test_read_back();
        xfer0(1'b0, 32'd4, 32'h0);
        tests_run++;
        if (b0.PRDATA1 !== 32'd15) begin tests_failed++; $display("FAIL read_addr4: got %h want f", b0.PRDATA1); end
        xfer0(1'b0, 32'd16, 32'h0);
        tests_run++;
        if (b0.PRDATA1 !== 32'h22) begin tests_failed++; $display("FAIL read_addr16: got %h want 22", b0.PRDATA1); end
        xfer0(1'b1, 32'd20, 32'h33);
        tests_run++;
        if (b0.PRDATA1 !== 32'h22) begin tests_failed++; $display("FAIL prdata1_hold_on_write: got %h want 22", b0.PRDATA1); end
        xfer0(1'b0, 32'd8, 32'h0);
        tests_run++;
        if (b0.PRDATA1 !== 32'h0) begin tests_failed++; $display("FAIL read_addr8: got %h want 0", b0.PRDATA1); end
        xfer0(1'b0, 32'd20, 32'h0);
        tests_run++;
        if (b0.PRDATA1 !== 32'h33) begin tests_failed++; $display("FAIL read_addr20: got %h want 33", b0.PRDATA1); end
    endtask

    task automatic test_abort();
        xfer0(1'b0, 32'd4, 32'h0);
        // Abort during SETUP.
        b0.PSEL = 1'b1; b0.transfer = 1'b1; b0.PWRITE = 1'b1;
        b0.PADDR = 32'd4; b0.PDATA = 32'hDEAD;
        step();
        idle0();
        b0.PWRITE = 1'b1;
        step();
        tests_run++;
        if (b0.PENABLE !== 1'b0) begin tests_failed++; $display("FAIL abort_setup_penable: got %b want 0", b0.PENABLE); end
        step();
        tests_run++;
        if (b0.PENABLE !== 1'b0) begin tests_failed++; $display("FAIL abort_setup_stays_idle: got %b want 0", b0.PENABLE); end
        // Abort during ACCESS.
        b0.PSEL = 1'b1; b0.transfer = 1'b1; b0.PWRITE = 1'b1;
        b0.PADDR = 32'd4; b0.PDATA = 32'hBEEF;
        step();
        b0.transfer = 1'b0;
        step();
        tests_run++;
        if (b0.PENABLE !== 1'b1) begin tests_failed++; $display("FAIL abort_reach_access: got %b want 1", b0.PENABLE); end
        b0.PSEL = 1'b0;
        #1;
        tests_run++;
        if (b0.PREADY !== 1'b0) begin tests_failed++; $display("FAIL abort_pready: got %b want 0", b0.PREADY); end
        step();
        tests_run++;
        if (b0.PENABLE !== 1'b0 || b0.PRDATA1 !== 32'd15) begin
            tests_failed++; $display("FAIL abort_access: got penable %b prdata1 %h want 0 f", b0.PENABLE, b0.PRDATA1);
        end
        idle0();
        xfer0(1'b0, 32'd4, 32'h0);
        tests_run++;
        if (b0.PRDATA1 !== 32'd15) begin tests_failed++; $display("FAIL abort_mem_unchanged: got %h want f", b0.PRDATA1); end
    endtask

    task automatic test_wait_states();
        int pen_cycles;
        int rdy_cycles;
        int rdy_pos;
        pen_cycles = 0;
        rdy_cycles = 0;
        rdy_pos    = -1;
        b2.PSEL = 1'b1; b2.transfer = 1'b1; b2.PWRITE = 1'b1;
        b2.PADDR = 32'd12; b2.PDATA = 32'hA5;
        step();
        b2.transfer = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (b2.PENABLE === 1'b1) pen_cycles++;
            if (b2.PREADY === 1'b1) begin
                rdy_cycles++;
                rdy_pos = i;
            end
        end
        idle2();
        tests_run++;
        if (pen_cycles != 3) begin tests_failed++; $display("FAIL wait_penable_cycles: got %0d want 3", pen_cycles); end
        tests_run++;
        if (rdy_cycles != 1 || rdy_pos != 2) begin
            tests_failed++; $display("FAIL wait_pready: got count %0d pos %0d want 1 2", rdy_cycles, rdy_pos);
        end
        b2.PSEL = 1'b1; b2.transfer = 1'b1; b2.PWRITE = 1'b0; b2.PADDR = 32'd12;
        step();
        b2.transfer = 1'b0;
        for (int i = 0; i < 4; i++) step();
        idle2();
        tests_run++;
        if (b2.PRDATA1 !== 32'hA5) begin tests_failed++; $display("FAIL wait_readback: got %h want a5", b2.PRDATA1); end
    endtask

    task automatic test_wrap();
        xfer0(1'b1, 32'd68, 32'h77);
        xfer0(1'b0, 32'd4, 32'h0);
        tests_run++;
        if (b0.PRDATA1 !== 32'h77) begin tests_failed++; $display("FAIL wrap_read4: got %h want 77", b0.PRDATA1); end
        xfer0(1'b0, 32'd0, 32'h0);
        xfer0(1'b0, 32'd7, 32'h0);
        tests_run++;
        if (b0.PRDATA1 !== 32'h77) begin tests_failed++; $display("FAIL byte_lane_ignored: got %h want 77", b0.PRDATA1); end
    endtask

    task automatic test_reset_mid_access();
        b0.PSEL = 1'b1; b0.transfer = 1'b1; b0.PWRITE = 1'b1;
        b0.PADDR = 32'd8; b0.PDATA = 32'h55;
        step();
        b0.transfer = 1'b0;
        step();
        tests_run++;
        if (b0.PENABLE !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_reach_access: got %b want 1", b0.PENABLE); end
        PRESET = 1'b1;
        step();
        tests_run++;
        if (b0.PENABLE !== 1'b0 || b0.PRWADDR !== 32'h0 || b0.PRDATA1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got penable %b addr %h prdata1 %h want 0 0 0", b0.PENABLE, b0.PRWADDR, b0.PRDATA1);
        end
        PRESET = 1'b0;
        idle0();
        step();
        xfer0(1'b0, 32'd8, 32'h0);
        tests_run++;
        if (b0.PRDATA1 !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_no_commit: got %h want 0", b0.PRDATA1); end
        xfer0(1'b1, 32'd12, 32'h1);
        xfer0(1'b0, 32'd4, 32'h0);
        tests_run++;
        if (b0.PRDATA1 !== 32'h0) begin tests_failed++; $display("FAIL rst_mem_cleared: got %h want 0", b0.PRDATA1); end
    endtask

    initial begin
        PRESET = 1'b1;
        idle0();
        idle2();
        test_reset();
        test_write();
        test_read_back();
        test_abort();
        test_wait_states();
        test_wrap();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
